// File: rtl/rx_pkg.sv
// Shared types and constants for the 4x-oversampled receive deserializer.
// Frame is FRAME_BYTES bytes; the last byte carries CRC-8 (poly 0x07, MSB-first).
package rx_pkg;
  typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;

  localparam int SAMPLES_PER_BIT = 4;
  localparam int FRAME_BYTES     = 9;
  localparam int MAJ_THRESH      = 3;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/rx_bit_slicer.sv
// Majority slicer: counts ones over SAMPLES_PER_BIT samples; decision is combinational on the last sample.
// No backpressure; bit_valid is a single-cycle qualifier for bit_val/bit_amb.
module rx_bit_slicer
  import rx_pkg::*;
(
  input  logic sample_clk,
  input  logic reset,
  input  logic first,
  input  logic en,
  input  logic signal,
  output logic bit_valid,
  output logic bit_val,
  output logic bit_amb
);
  localparam int SW = $clog2(SAMPLES_PER_BIT);
  localparam int OW = $clog2(SAMPLES_PER_BIT + 1);
  localparam logic [SW-1:0] LAST = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [OW-1:0] HI   = OW'(MAJ_THRESH);
  localparam logic [OW-1:0] LO   = OW'(SAMPLES_PER_BIT - MAJ_THRESH);

  logic [SW-1:0] sample_cnt;
  logic [OW-1:0] ones_cnt;
  logic [OW-1:0] ones_total;

  // The current sample is part of the decision on the last sample of a bit.
  assign ones_total = ones_cnt + OW'(signal);
  assign bit_valid  = en && (sample_cnt == LAST);
  assign bit_val    = (ones_total >= HI);
  assign bit_amb    = bit_valid && (ones_total > LO) && (ones_total < HI);

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
    end else if (first) begin
      // The triggering edge already captures sample 0 of bit 0.
      sample_cnt <= SW'(1);
      ones_cnt   <= OW'(signal);
    end else if (en) begin
      if (bit_valid) begin
        sample_cnt <= '0;
        ones_cnt   <= '0;
      end else begin
        sample_cnt <= sample_cnt + SW'(1);
        ones_cnt   <= ones_total;
      end
    end
  end
endmodule

// File: rtl/rx_frame_deserializer.sv
// Frame deserializer: start rise -> FRAME_BYTES registered byte strobes, first on sample 31, last on 287.
// No backpressure (consumers must accept every strobe); optional inline CRC-8 under `RX_CRC8_EN`.
module rx_frame_deserializer
  import rx_pkg::*;
(
  input  logic       sample_clk,
  input  logic       reset,
  input  logic       signal,
  input  logic       start,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [3:0] byte_index,
  output logic       frame_done,
  output logic       bit_err,
  output logic       busy,
  output logic       crc_ok
);
  localparam int BW = $clog2(FRAME_BYTES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);

  state_t        state;
  logic          start_prev;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [7:0]    shreg;
  logic [7:0]    shreg_nxt;
  logic          rise, frame_start;
  logic          bit_valid, bit_val, bit_amb;

  assign rise        = start & ~start_prev;
  assign frame_start = (state == IDLE) && rise;
  assign shreg_nxt   = {shreg[6:0], bit_val};

  rx_bit_slicer u_slicer (
    .sample_clk (sample_clk),
    .reset      (reset),
    .first      (frame_start),
    .en         (state == RECEIVE),
    .signal     (signal),
    .bit_valid  (bit_valid),
    .bit_val    (bit_val),
    .bit_amb    (bit_amb)
  );

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state      <= IDLE;
      start_prev <= 1'b1;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      byte_index <= '0;
      frame_done <= 1'b0;
      bit_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      start_prev <= start;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= RECEIVE;
            busy     <= 1'b1;
            bit_err  <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
          end
        end
        RECEIVE: begin
          if (bit_valid) begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_amb) bit_err <= 1'b1;
            if (bit_cnt == 3'd7) begin
              data_out   <= shreg_nxt;
              byte_index <= 4'(byte_cnt);
              data_valid <= 1'b1;
              byte_cnt   <= byte_cnt + BW'(1);
              if (byte_cnt == LAST_BYTE) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= DONE;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_CRC8_EN
  logic [7:0] crc;

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      crc    <= CRC8_INIT;
      crc_ok <= 1'b0;
    end else if (frame_start) begin
      crc    <= CRC8_INIT;
      crc_ok <= 1'b0;
    end else if (bit_valid) begin
      // Payload bits feed the CRC; the final byte is compared once fully shifted in.
      if (byte_cnt != LAST_BYTE)
        crc <= crc8_step(crc, bit_val);
      else if (bit_cnt == 3'd7)
        crc_ok <= (crc == shreg_nxt);
    end
  end
`else
  assign crc_ok = 1'b0;
`endif
endmodule

// File: tb/tb_rx_frame_deserializer.sv
// Directed bench for rx_frame_deserializer with a byte scoreboard checked on every strobe.
module tb_rx_frame_deserializer;
  logic       sample_clk = 1'b0;
  logic       reset = 1'b1;
  logic       signal = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] byte_index;
  logic       frame_done;
  logic       bit_err;
  logic       busy;
  logic       crc_ok;

  rx_frame_deserializer dut (
    .sample_clk (sample_clk),
    .reset      (reset),
    .signal     (signal),
    .start      (start),
    .data_out   (data_out),
    .data_valid (data_valid),
    .byte_index (byte_index),
    .frame_done (frame_done),
    .bit_err    (bit_err),
    .busy       (busy),
    .crc_ok     (crc_ok)
  );

  always #5 sample_clk = ~sample_clk;

  typedef struct {
    logic [7:0] dat;
    logic [3:0] idx;
    logic       last;
    logic       err;
    logic       crc;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         strobes = 0;
  int         cyc = 0;
  int         trig_cyc = 0;
  int         base = 0;
  logic [7:0] pl [8];
  logic [7:0] ex [9];
  logic       eu [9];
  logic       crc_exp;
  logic       smp [288];

  always @(posedge sample_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] golden_crc();
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < 8; k++) begin
      c = c ^ ex[k];
      for (int i = 0; i < 8; i++)
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Builds the sample stream and expected bytes; amb_pos is MSB-first bit position.
  task automatic build(input int amb_byte, input int amb_pos, input bit noisy0, input logic [7:0] corrupt);
    logic       any_err;
    logic       v;
    logic [3:0] p;
    any_err = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ex[k] = pl[k];
      if (k == amb_byte) ex[k] = ex[k] & ~(8'h80 >> amb_pos);
    end
    ex[8] = golden_crc() ^ corrupt;
`ifdef RX_CRC8_EN
    crc_exp = (corrupt == 8'h00);
`else
    crc_exp = 1'b0;
`endif
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) begin
        v = ex[k][7-i];
        if (k == amb_byte && i == amb_pos) begin
          p = 4'b1100;
          any_err = 1'b1;
        end else if (noisy0 && k == 0) begin
          p = v ? 4'b1101 : 4'b0010;
        end else begin
          p = {4{v}};
        end
        for (int j = 0; j < 4; j++) smp[(k*8+i)*4+j] = p[3-j];
      end
      eu[k] = any_err;
    end
  endtask

  // Plays samples 0..stop_at-1; returns #1 after the edge capturing sample stop_at-1.
  task automatic play(input int retrig_at, input int stop_at);
    exp_t e;
    for (int k = 0; k < 9; k++) begin
      if (32*k + 31 < stop_at) begin
        e.dat  = ex[k];
        e.idx  = 4'(k);
        e.last = (k == 8);
        e.err  = eu[k];
        e.crc  = crc_exp;
        e.lat  = 32*k + 31;
        sb.push_back(e);
      end
    end
    start  = 1'b1;
    signal = smp[0];
    @(posedge sample_clk); #1;
    trig_cyc = cyc;
    for (int s = 1; s < stop_at; s++) begin
      if (s == 4) start = 1'b0;
      if (retrig_at > 0 && s == retrig_at) start = 1'b1;
      if (retrig_at > 0 && s == retrig_at + 3) start = 1'b0;
      if (s == 50) chk("busy_mid", busy, 1);
      signal = smp[s];
      @(posedge sample_clk); #1;
    end
  endtask

  task automatic settle(input int b);
    repeat (4) @(posedge sample_clk);
    #1;
    chk("strobe_count", strobes - b, 9);
    chk("sb_drained", sb.size(), 0);
    chk("busy_after", busy, 0);
    chk("data_hold", data_out, ex[8]);
    chk("index_hold", byte_index, 8);
    chk("crc_ok_held", crc_ok, crc_exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_byte_index"}, byte_index, 0);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_bit_err"}, bit_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_crc_ok"}, crc_ok, 0);
  endtask

  always @(negedge sample_clk) begin
    exp_t e;
    if (data_valid === 1'b1) begin
      strobes++;
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data_out", data_out, e.dat);
        chk("byte_index", byte_index, e.idx);
        chk("frame_done", frame_done, e.last);
        chk("bit_err", bit_err, e.err);
        chk("latency", cyc - trig_cyc, e.lat);
        if (e.last) chk("crc_ok", crc_ok, e.crc);
      end
    end else if (frame_done !== 1'b0) begin
      chk("frame_done_alone", frame_done, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    signal = 1'b0;
    repeat (3) @(posedge sample_clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    @(posedge sample_clk); #1;

    // Clean frame
    pl = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h12, 8'h34};
    base = strobes;
    build(-1, -1, 1'b0, 8'h00);
    play(-1, 288);
    settle(base);
    chk("clean_bit_err", bit_err, 0);

    // Noisy byte 0 plus one ambiguous bit in byte 1
    base = strobes;
    build(1, 2, 1'b1, 8'h00);
    play(-1, 288);
    settle(base);
    chk("noisy_bit_err_sticky", bit_err, 1);

    // Retrigger mid-frame, then a rise during DONE that must not start a frame
    pl = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hC3, 8'h3C, 8'hF0, 8'h0F};
    base = strobes;
    build(-1, -1, 1'b0, 8'h00);
    play(100, 288);
    start = 1'b1;
    repeat (10) @(posedge sample_clk);
    #1;
    chk("done_rise_ignored_busy", busy, 0);
    start = 1'b0;
    settle(base);

    // Reset mid-frame at sample 150
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44};
    base = strobes;
    build(-1, -1, 1'b0, 8'h00);
    play(-1, 150);
    reset = 1'b1;
    @(posedge sample_clk); #1;
    chk_zero("midreset");
    reset = 1'b0;
    repeat (300) @(posedge sample_clk);
    #1;
    chk("midreset_strobes", strobes - base, 4);
    chk("midreset_sb_empty", sb.size(), 0);
    chk("midreset_busy", busy, 0);

    base = strobes;
    play(-1, 288);
    settle(base);

    // Start held high across reset release
    base = strobes;
    start = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge sample_clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge sample_clk);
    #1;
    chk("held_start_busy", busy, 0);
    chk("held_start_strobes", strobes - base, 0);
    start = 1'b0;
    @(posedge sample_clk); #1;
    play(-1, 288);
    settle(base);

    // Corrupted CRC byte
    base = strobes;
    build(-1, -1, 1'b0, 8'h01);
    play(-1, 288);
    settle(base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
